frame_tx_serializer: RTL
========================

// Module: frame_tx_serializer
// PURPOSE
//  Transmit-side framer for the host series link. Builds outbound frames for the UART TX path.
//  Each frame is a 12-byte header followed by a payload:
//  - Header: release_id, series_id and length, each 32-bit little-endian.
//  - Payload: `length` 16-bit samples, each sent LSB first.
//  - Trailer: an optional XOR checksum byte.
//  Samples come from the SMA/EMA result path through an internal FIFO, so results can arrive before or
//  during a frame. Bytes are paced with the uartInterface send/tx_ready handshake.
// PARAMETERS
//  FIFO_DEPTH   16  sample FIFO entries, power of 2, >=2
//  CHECKSUM_EN  0   1: append 8-bit XOR of all header and payload bytes after the last sample
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   asynchronous, active-low reset
//  start         in   1   one-cycle request to begin a frame; honoured only when busy=0
//  release_id    in   32  latched at the accepted start
//  series_id     in   32  latched at the accepted start
//  length        in   32  sample count, latched at the accepted start; 0 is legal
//  sample_in     in   16  result sample
//  sample_valid  in   1   push sample_in into the FIFO this cycle
//  fifo_full     out  1   FIFO holds FIFO_DEPTH entries
//  overflow      out  1   sticky: a push was dropped because the FIFO was full; cleared by an accepted start
//  busy          out  1   high from the cycle after an accepted start until frame_done
//  frame_done    out  1   one-cycle pulse after the handshake for the last byte of the frame
//  uart_data_in  out  8   byte to transmit; stable whenever uart_send=1
//  uart_send     out  1   one-cycle send strobe to uartInterface
//  uart_ready    in   1   uartInterface transmitter idle
// BEHAVIOUR
//  - Reset values: all outputs 0, FSM in IDLE, FIFO empty, latched fields 0.
//    Reset mid-frame aborts the frame: no further bytes, no frame_done, FIFO contents discarded.
//  - All outputs are registered.
//  - Send rule: uart_send may pulse only when uart_ready=1 and uart_send was 0 in the previous cycle.
//    This guard cycle lets tx_ready fall. Minimum spacing between bytes is therefore 2 clocks.
//  - FSM states and transitions:
//    IDLE: on start, latch the fields, clear overflow, set byte_idx=0, go to HDR.
//    HDR: send header byte byte_idx, where bytes 0-3 are release_id[7:0]..[31:24], 4-7 are series_id,
//      and 8-11 are length. After byte 11:
//      - if length==0: go to CSUM when CHECKSUM_EN=1, else DONE;
//      - otherwise go to PAY_LO.
//    PAY_LO: wait for FIFO non-empty and the send rule. Pop the FIFO into hold, send hold[7:0],
//      go to PAY_HI.
//    PAY_HI: send hold[15:8] and increment sent_cnt (32-bit).
//      - if sent_cnt+1==length: go to CSUM when CHECKSUM_EN=1, else DONE;
//      - otherwise go to PAY_LO.
//    CSUM: send the running XOR, go to DONE.
//    DONE: pulse frame_done, go to IDLE.
//  - The checksum is cleared at an accepted start. It XORs each byte in the cycle that byte is strobed.
//  - start while busy=1 is ignored and none of the latched fields change.
//  - FIFO:
//    - Pushes are accepted in every state.
//    - Push when full: the sample is dropped, overflow is set, the FIFO is unchanged.
//    - Simultaneous push and pop when full: the pop frees a slot, the push is accepted, and overflow
//      is not set.
//    - Pointers wrap modulo FIFO_DEPTH. fifo_full and empty come from a count register (width clog2+1).
//  - Samples left in the FIFO after frame_done are kept for the next frame.
//  - An empty FIFO in PAY_LO stalls the FSM indefinitely, with no timeout.
//  - Latency: an accepted start with uart_ready held at 1 gives the first uart_send 2 cycles later.
// STRUCTURE
//  - Package frame_pkg: HDR_BYTES=12; typedef tx_state_t {IDLE,HDR,PAY_LO,PAY_HI,CSUM,DONE};
//    shared frame field widths (ID_W=32, LEN_W=32, SAMPLE_W=16). The RX framer also imports this package.
//  - Sub-module sample_fifo #(WIDTH=16, DEPTH): synchronous FIFO with push, pop, rdata, full, empty and
//    count. It uses the async active-low reset and provides first-word fall-through on rdata.
// TESTING
//  1. Header only: length=0, rel=0x04030201, ser=0x08070605, CHECKSUM_EN=0, uart_ready=1.
//     -> 12 bytes 01 02 03 04 05 06 07 08 00 00 00 00, then frame_done, busy=0.
//  2. Payload: push 0x1234 and 0xABCD, start with length=2.
//     -> header bytes, then 34 12 CD AB, one frame_done, FIFO empty.
//  3. Stall and pacing: length=1 with an empty FIFO; hold uart_ready=0 for 5 cycles after each strobe.
//     -> no byte is sent until the sample is pushed, never two strobes per ready window, bytes in order.
//  4. Overflow: FIFO_DEPTH=4, push 5 samples while idle.
//     -> fifo_full=1, overflow=1, first 4 samples kept. Next start clears overflow and sends the 4 in order.
//  5. Checksum: CHECKSUM_EN=1, length=1, all ids 0, sample 0x00FF.
//     -> the 15th byte is 0x01^0xFF=0xFE (only the length LSB and the FF byte are nonzero).
//  6. Reset mid-payload and start while busy.
//     -> a start pulse in HDR changes nothing. reset_n low after 3 payload bytes: outputs 0, no frame_done,
//        FIFO empty, and the next frame is sent correctly from byte 0.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared framing definitions for the host series link (TX and RX framers).
package frame_pkg;

   localparam int HDR_BYTES = 12;
   localparam int ID_W      = 32;
   localparam int LEN_W     = 32;
   localparam int SAMPLE_W  = 16;
   localparam int HDR_W     = 2 * ID_W + LEN_W;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PAY_LO,
      PAY_HI,
      CSUM,
      DONE
   } tx_state_t;

   // Header layout on the wire: release_id, series_id, length, each little-endian.
   function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0]  rel,
                                           input logic [ID_W-1:0]  ser,
                                           input logic [LEN_W-1:0] len,
                                           input logic [3:0]       idx);
      logic [HDR_W-1:0] hdr;
      hdr = {len, ser, rel};
      return hdr[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/frame_tx_serializer_if.sv
// Host-side bundle of the TX framer: frame request, sample push, status and UART byte handshake.
interface frame_tx_serializer_if;
   import frame_pkg::*;

   logic                start;
   logic [ID_W-1:0]     release_id;
   logic [ID_W-1:0]     series_id;
   logic [LEN_W-1:0]    length;
   logic [SAMPLE_W-1:0] sample_in;
   logic                sample_valid;
   logic                fifo_full;
   logic                overflow;
   logic                busy;
   logic                frame_done;
   logic [7:0]          uart_data_in;
   logic                uart_send;
   logic                uart_ready;

   modport master (
      output start, release_id, series_id, length, sample_in, sample_valid, uart_ready,
      input  fifo_full, overflow, busy, frame_done, uart_data_in, uart_send
   );

   modport slave (
      input  start, release_id, series_id, length, sample_in, sample_valid, uart_ready,
      output fifo_full, overflow, busy, frame_done, uart_data_in, uart_send
   );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with first-word fall-through read data and registered full/empty flags.
module sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_pop  = pop_i && !empty_q;
   assign do_push = push_i && (!full_q || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
         full_q  <= (count_d == CNT_MAX);
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule

// File: rtl/frame_tx_serializer.sv
// Transmit framer: 12-byte header, length 16-bit samples LSB first, optional XOR checksum byte,
// paced byte by byte on the uartInterface send/tx_ready handshake.
module frame_tx_serializer
   import frame_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter bit CHECKSUM_EN = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   frame_tx_serializer_if.slave  tx_if
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0] LAST_HDR = 4'(HDR_BYTES - 1);

   tx_state_t           state_q;
   logic [ID_W-1:0]     rel_q, ser_q;
   logic [LEN_W-1:0]    len_q, sent_cnt_q, sent_cnt_d;
   logic [3:0]          byte_idx_q;
   logic [SAMPLE_W-1:0] hold_q;
   logic [7:0]          csum_q, uart_data_q;
   logic                uart_send_q, busy_q, frame_done_q, overflow_q;

   logic                can_send, fifo_pop, push_drop;
   logic                fifo_full, fifo_empty;
   logic [SAMPLE_W-1:0] fifo_rdata;
   logic [CNT_W-1:0]    fifo_count;
   logic [7:0]          hdr_b;

   sample_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (tx_if.sample_valid),
      .pop_i   (fifo_pop),
      .wdata_i (tx_if.sample_in),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // The guard cycle after every strobe gives the transmitter time to drop tx_ready.
   assign can_send   = tx_if.uart_ready && !uart_send_q;
   assign fifo_pop   = (state_q == PAY_LO) && !fifo_empty && can_send;
   assign push_drop  = tx_if.sample_valid && (fifo_count == CNT_W'(FIFO_DEPTH)) && !fifo_pop;
   assign hdr_b      = hdr_byte(rel_q, ser_q, len_q, byte_idx_q);
   assign sent_cnt_d = sent_cnt_q + 32'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rel_q        <= '0;
         ser_q        <= '0;
         len_q        <= '0;
         sent_cnt_q   <= '0;
         byte_idx_q   <= '0;
         hold_q       <= '0;
         csum_q       <= '0;
         uart_data_q  <= '0;
         uart_send_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         uart_send_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (push_drop) overflow_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (tx_if.start) begin
                  rel_q      <= tx_if.release_id;
                  ser_q      <= tx_if.series_id;
                  len_q      <= tx_if.length;
                  overflow_q <= push_drop;
                  csum_q     <= '0;
                  byte_idx_q <= '0;
                  sent_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= HDR;
               end
            end

            HDR: begin
               if (can_send) begin
                  uart_send_q <= 1'b1;
                  uart_data_q <= hdr_b;
                  csum_q      <= csum_q ^ hdr_b;
                  if (byte_idx_q == LAST_HDR) begin
                     if (len_q != '0)      state_q <= PAY_LO;
                     else if (CHECKSUM_EN) state_q <= CSUM;
                     else                  state_q <= DONE;
                  end else begin
                     byte_idx_q <= byte_idx_q + 4'd1;
                  end
               end
            end

            PAY_LO: begin
               if (fifo_pop) begin
                  hold_q      <= fifo_rdata;
                  uart_send_q <= 1'b1;
                  uart_data_q <= fifo_rdata[7:0];
                  csum_q      <= csum_q ^ fifo_rdata[7:0];
                  state_q     <= PAY_HI;
               end
            end

            PAY_HI: begin
               if (can_send) begin
                  uart_send_q <= 1'b1;
                  uart_data_q <= hold_q[15:8];
                  csum_q      <= csum_q ^ hold_q[15:8];
                  sent_cnt_q  <= sent_cnt_d;
                  if (sent_cnt_d != len_q) state_q <= PAY_LO;
                  else if (CHECKSUM_EN)    state_q <= CSUM;
                  else                     state_q <= DONE;
               end
            end

            CSUM: begin
               if (can_send) begin
                  uart_send_q <= 1'b1;
                  uart_data_q <= csum_q;
                  state_q     <= DONE;
               end
            end

            DONE: begin
               frame_done_q <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_if.fifo_full    = fifo_full;
   assign tx_if.overflow     = overflow_q;
   assign tx_if.busy         = busy_q;
   assign tx_if.frame_done   = frame_done_q;
   assign tx_if.uart_data_in = uart_data_q;
   assign tx_if.uart_send    = uart_send_q;

endmodule
